// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared widths, op encodings and sequencer states for the HI/LO multiply/divide unit
package muldiv_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
endpackage

// File: rtl/muldiv_hilo_ctl_if.sv
// muldiv_hilo_ctl_if: request/result bundle between the core and the multiply/divide sequencer
interface muldiv_hilo_ctl_if;
  import muldiv_pkg::*;
  logic start_i;
  logic [1:0] op_i;
  logic [DATA_W-1:0] rs_val_i;
  logic [DATA_W-1:0] rt_val_i;
  logic mthi_i;
  logic mtlo_i;
  logic mfhi_req_i;
  logic mflo_req_i;
  logic busy_o;
  logic stall_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic done_o;
  logic div_by_zero_o;
  modport master(output start_i, op_i, rs_val_i, rt_val_i, mthi_i, mtlo_i, mfhi_req_i, mflo_req_i,
                 input busy_o, stall_o, hi_o, lo_o, done_o, div_by_zero_o);
  modport slave(input start_i, op_i, rs_val_i, rt_val_i, mthi_i, mtlo_i, mfhi_req_i, mflo_req_i,
                output busy_o, stall_o, hi_o, lo_o, done_o, div_by_zero_o);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration on {acc, q}: add-and-shift-right for multiply, trial-subtract-and-shift-left for divide
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              div,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] acc_n,
  output logic [DATA_W-1:0] q_n
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] rem;
  logic fits;
  always_comb begin
    sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    rem = {acc, q[DATA_W-1]};
    fits = rem >= {1'b0, m};
    acc_n = div ? (fits ? DATA_W'(rem - {1'b0, m}) : rem[DATA_W-1:0]) : sum[DATA_W:1];
    q_n = div ? {q[DATA_W-2:0], fits} : {sum[0], q[DATA_W-1:1]};
  end
endmodule

// File: rtl/muldiv_hilo_ctl.sv
// muldiv_hilo_ctl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MULDIV_FAST_MUL_EN selects a single-cycle multiply
module muldiv_hilo_ctl
  import muldiv_pkg::*;
(
  input logic clk,
  input logic rst,
  muldiv_hilo_ctl_if.slave bus
);
  state_e state;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] acc, q, m, hi, lo, acc_n, q_n, mag_a, mag_b, fix_hi, fix_lo;
  logic [2*DATA_W-1:0] prod;
  logic is_div, neg_q, neg_r, dz, busy, done, dbz, sgn;
  muldiv_step u_step (.div(state == DIV), .acc(acc), .q(q), .m(m), .acc_n(acc_n), .q_n(q_n));
  // Operands run as magnitudes; the captured sign flags restore signs in FIX.
  always_comb begin
    sgn = bus.op_i inside {OP_MULT, OP_DIV};
    mag_a = (sgn && bus.rs_val_i[DATA_W-1]) ? -bus.rs_val_i : bus.rs_val_i;
    mag_b = (sgn && bus.rt_val_i[DATA_W-1]) ? -bus.rt_val_i : bus.rt_val_i;
    prod = neg_q ? -{acc, q} : {acc, q};
    fix_hi = is_div ? (neg_r ? -acc : acc) : prod[2*DATA_W-1:DATA_W];
    fix_lo = is_div ? (neg_q ? -q : q) : prod[DATA_W-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      q <= '0;
      m <= '0;
      hi <= '0;
      lo <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      dbz <= 1'b0;
    end else begin
      done <= 1'b0;
      dbz <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            is_div <= bus.op_i[1];
            neg_q <= sgn && (bus.rs_val_i[DATA_W-1] ^ bus.rt_val_i[DATA_W-1]);
            neg_r <= sgn && bus.rs_val_i[DATA_W-1];
            dz <= bus.op_i[1] && (bus.rt_val_i == '0);
            m <= mag_b;
            cnt <= '1;
            busy <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            {acc, q} <= bus.op_i[1] ? {{DATA_W{1'b0}}, mag_a} : (2*DATA_W)'(mag_a) * (2*DATA_W)'(mag_b);
            state <= (!bus.op_i[1] || bus.rt_val_i == '0) ? FIX : DIV;
`else
            acc <= '0;
            q <= mag_a;
            state <= bus.op_i[1] ? ((bus.rt_val_i == '0) ? FIX : DIV) : MUL;
`endif
          end else begin
            if (bus.mthi_i) hi <= bus.rs_val_i;
            if (bus.mtlo_i) lo <= bus.rs_val_i;
          end
        end
        MUL, DIV: begin
          acc <= acc_n;
          q <= q_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          dbz <= dz;
          if (!dz) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
        end
      endcase
    end
  end
  assign bus.busy_o = busy;
  assign bus.stall_o = busy & (bus.start_i | bus.mthi_i | bus.mtlo_i | bus.mfhi_req_i | bus.mflo_req_i);
  assign bus.hi_o = hi;
  assign bus.lo_o = lo;
  assign bus.done_o = done;
  assign bus.div_by_zero_o = dbz;
endmodule

// File: tb/tb_muldiv_hilo_ctl.sv
// tb_muldiv_hilo_ctl: directed vectors plus an arithmetic reference model checked every cycle
module tb_muldiv_hilo_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  muldiv_hilo_ctl_if bus();
  muldiv_hilo_ctl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: 64-bit integer arithmetic on the operands, results land after the op's latency.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    logic [63:0] qv, rv;
    sa = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!op[1]) begin
      r = sa * sb;
      return 64'(r);
    end
    qv = 64'(sa / sb);
    rv = 64'(sa % sb);
    return {rv[31:0], qv[31:0]};
  endfunction

  int left;
  logic [31:0] mhi, mlo, phi, plo;
  logic pdz, mdone, mdbz;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      left <= 0; mhi <= '0; mlo <= '0; mdone <= 1'b0; mdbz <= 1'b0; pdz <= 1'b0; phi <= '0; plo <= '0;
    end else begin
      mdone <= 1'b0;
      mdbz <= 1'b0;
      if (left == 0) begin
        if (bus.start_i) begin
          pdz <= bus.op_i[1] && bus.rt_val_i == 0;
          left <= (bus.op_i[1] && bus.rt_val_i == 0) ? 1 : (bus.op_i[1] ? 33 : MUL_LAT - 1);
          if (!(bus.op_i[1] && bus.rt_val_i == 0)) {phi, plo} <= ref_res(bus.op_i, bus.rs_val_i, bus.rt_val_i);
        end else begin
          if (bus.mthi_i) mhi <= bus.rs_val_i;
          if (bus.mtlo_i) mlo <= bus.rs_val_i;
        end
      end else begin
        left <= left - 1;
        if (left == 1) begin
          mdone <= 1'b1;
          mdbz <= pdz;
          if (!pdz) begin
            mhi <= phi;
            mlo <= plo;
          end
        end
      end
    end
  end

  bit started = 0;
  initial forever begin
    @(negedge clk);
    #2;
    if (started && !rst) begin
      chk("busy", 32'(bus.busy_o), 32'(left != 0));
      chk("stall", 32'(bus.stall_o), 32'((left != 0) && (bus.start_i || bus.mthi_i || bus.mtlo_i || bus.mfhi_req_i || bus.mflo_req_i)));
      chk("done", 32'(bus.done_o), 32'(mdone));
      chk("dbz", 32'(bus.div_by_zero_o), 32'(mdbz));
      chk("hi", bus.hi_o, mhi);
      chk("lo", bus.lo_o, mlo);
    end
  end

  int st33, st34;
  // mode 0: plain, 1: hold mflo_req from start+1, 2: MTHI 0x1234 attempted while busy
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit edz, input int lat, input int mode);
    int c;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = op; bus.rs_val_i = a; bus.rt_val_i = b;
    @(negedge clk);
    bus.start_i = 1'b0; bus.rs_val_i = $urandom; bus.rt_val_i = $urandom;
    if (mode == 1) bus.mflo_req_i = 1'b1;
    c = 1;
    while (!bus.done_o && c < 200) begin
      @(negedge clk);
      c++;
      if (mode == 1 && c == 33) st33 = int'(bus.stall_o);
      if (mode == 2 && c == 5) begin bus.mthi_i = 1'b1; bus.rs_val_i = 32'h1234; end
      if (mode == 2 && c == 6) begin bus.mthi_i = 1'b0; bus.rs_val_i = $urandom; end
    end
    if (mode == 1) begin st34 = int'(bus.stall_o); bus.mflo_req_i = 1'b0; end
    chk({name, "_lat"}, 32'(c), 32'(lat));
    chk({name, "_hi"}, bus.hi_o, eh);
    chk({name, "_lo"}, bus.lo_o, el);
    chk({name, "_dz"}, 32'(bus.div_by_zero_o), 32'(edz));
  endtask

  initial begin
    bus.start_i = 0; bus.op_i = 0; bus.rs_val_i = 0; bus.rt_val_i = 0;
    bus.mthi_i = 0; bus.mtlo_i = 0; bus.mfhi_req_i = 0; bus.mflo_req_i = 0;
    st33 = 0; st34 = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_hi", bus.hi_o, 0);
    chk("rst_lo", bus.lo_o, 0);
    rst = 1'b0;
    started = 1;
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, MUL_LAT, 0);
    run_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, MUL_LAT, 0);
    run_op("mult_min2", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0, MUL_LAT, 0);
    run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, 0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 34, 0);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, 34, 1);
    chk("stall_c33", 32'(st33), 1);
    chk("stall_c34", 32'(st34), 0);
    @(negedge clk);
    bus.mthi_i = 1'b1; bus.mtlo_i = 1'b1; bus.rs_val_i = 32'h77;
    @(negedge clk);
    bus.mtlo_i = 1'b0; bus.rs_val_i = 32'hAAAA;
    chk("mt_both_hi", bus.hi_o, 32'h77);
    chk("mt_both_lo", bus.lo_o, 32'h77);
    @(negedge clk);
    bus.mthi_i = 1'b0; bus.mtlo_i = 1'b1; bus.rs_val_i = 32'h5555;
    @(negedge clk);
    bus.mtlo_i = 1'b0;
    chk("pre_hi", bus.hi_o, 32'hAAAA);
    chk("pre_lo", bus.lo_o, 32'h5555);
    run_op("divu_dz", 2'b11, 32'd5, 32'd0, 32'hAAAA, 32'h5555, 1, 2, 0);
    run_op("multu_mthi_busy", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 0, MUL_LAT, 2);
    @(negedge clk);
    bus.mthi_i = 1'b1; bus.rs_val_i = 32'h1234;
    @(negedge clk);
    bus.mthi_i = 1'b0;
    chk("mthi_idle", bus.hi_o, 32'h1234);
    chk("mthi_idle_lo", bus.lo_o, 32'd42);
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b00; bus.rs_val_i = 32'd9; bus.rt_val_i = 32'd11;
    @(negedge clk);
    bus.start_i = 1'b0; bus.mflo_req_i = 1'b1;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy_o), 0);
    chk("arst_stall", 32'(bus.stall_o), 0);
    chk("arst_hi", bus.hi_o, 0);
    chk("arst_lo", bus.lo_o, 0);
    @(negedge clk);
    rst = 1'b0; bus.mflo_req_i = 1'b0;
    run_op("multu_3x4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 0, MUL_LAT, 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
